// File: rtl/pmu_core.sv
// Programming management unit: captures 192-bit serial command frames, loads a
// decryption key or stores XOR-decrypted words, and streams the stored words on tdo.
module pmu_core #(
  parameter int unsigned KEY_LENGTH       = 128,
  parameter int unsigned BITSTREAM_LENGTH = 128,
  parameter int unsigned HEADER_LENGTH    = 64,
  parameter int unsigned MEM_DEPTH        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data_i,
  input  logic en,
  input  logic pwr_up_en,
  output logic tdo
);

  localparam int unsigned FRAME_LENGTH = HEADER_LENGTH + KEY_LENGTH;
  localparam int unsigned CNT_W        = $clog2(FRAME_LENGTH);
  localparam int unsigned WPTR_W       = $clog2(MEM_DEPTH + 1);
  localparam int unsigned ADDR_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned BIT_W        = $clog2(BITSTREAM_LENGTH);
  localparam int unsigned RD_W         = WPTR_W + BIT_W;

  localparam logic [3:0] OP_LOAD_KEY = 4'h0;
  localparam logic [3:0] OP_LOAD_MEM = 4'h1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    EXEC,
    WAIT_EN_LOW,
    READOUT
  } state_e;

  state_e                      state_q;
  logic [CNT_W-1:0]            bit_cnt_q;
  logic [FRAME_LENGTH-1:0]     frame_q;
  logic [KEY_LENGTH-1:0]       key_q;
  logic                        key_valid_q;
  logic [WPTR_W-1:0]           wptr_q;
  logic [RD_W-1:0]             rd_cnt_q;
  logic                        en_prev_q;
  logic                        tdo_q;
  logic [BITSTREAM_LENGTH-1:0] mem_q [MEM_DEPTH];

  logic                        start_c;
  logic [3:0]                  opcode_c;
  logic [KEY_LENGTH-1:0]       payload_c;
  logic [BITSTREAM_LENGTH-1:0] mem_word_d;
  logic                        mem_wr_c;
  logic [ADDR_W-1:0]           rd_word_c;
  logic [BIT_W-1:0]            rd_bit_c;
  logic                        rd_data_c;
  logic [RD_W-1:0]             rd_total_c;

  // A start cycle is a rising edge of en; en held high never re-arms capture.
  assign start_c    = en && !en_prev_q;
  assign opcode_c   = frame_q[3:0];
  assign payload_c  = frame_q[FRAME_LENGTH-1 -: KEY_LENGTH];
  assign mem_word_d = payload_c ^ key_q;
  assign mem_wr_c   = (state_q == EXEC) && (opcode_c == OP_LOAD_MEM) && key_valid_q &&
                      (wptr_q < WPTR_W'(MEM_DEPTH));

  assign rd_word_c  = rd_cnt_q[BIT_W +: ADDR_W];
  assign rd_bit_c   = rd_cnt_q[BIT_W-1:0];
  assign rd_data_c  = mem_q[rd_word_c][rd_bit_c];
  assign rd_total_c = RD_W'({wptr_q, BIT_W'(0)});

  assign tdo = tdo_q;

  // Frame shift register: LSB-first data ends up with bit 0 at frame_q[0].
  always_ff @(posedge clk) begin
    if (state_q == SHIFT && en) begin
      frame_q <= {data_i, frame_q[FRAME_LENGTH-1:1]};
    end
  end

  // Configuration memory has no reset; only words below wptr are ever read out.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr_c) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= mem_word_d;
    end
  end

  // Control FSM with registered tdo.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      wptr_q      <= '0;
      rd_cnt_q    <= '0;
      en_prev_q   <= 1'b0;
      tdo_q       <= 1'b0;
    end else begin
      en_prev_q <= en;
      case (state_q)
        IDLE: begin
          tdo_q <= 1'b0;
          if (start_c) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
          end else if (pwr_up_en && !en && (wptr_q != '0)) begin
            state_q  <= READOUT;
            tdo_q    <= rd_data_c;
            rd_cnt_q <= RD_W'(1);
          end
        end
        SHIFT: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (bit_cnt_q == CNT_W'(FRAME_LENGTH - 1)) begin
            state_q <= EXEC;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        EXEC: begin
          if (opcode_c == OP_LOAD_KEY) begin
            key_q       <= payload_c;
            key_valid_q <= 1'b1;
          end
          if (mem_wr_c) begin
            wptr_q <= wptr_q + WPTR_W'(1);
          end
          state_q <= WAIT_EN_LOW;
        end
        WAIT_EN_LOW: begin
          if (!en) begin
            state_q <= IDLE;
          end
        end
        READOUT: begin
          if (rd_cnt_q == rd_total_c) begin
            state_q  <= IDLE;
            tdo_q    <= 1'b0;
            rd_cnt_q <= '0;
          end else begin
            tdo_q    <= rd_data_c;
            rd_cnt_q <= rd_cnt_q + RD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tdo_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_core.sv
// Bench for pmu_core: table of frame/readout steps with a scoreboard of expected
// readout words, plus hand sequences for overlap and mid-readout reset.
module tb_pmu_core;

  logic clk = 1'b0;
  logic rst;
  logic data_i;
  logic en;
  logic pwr_up_en;
  logic tdo;

  always #5 clk = ~clk;

  pmu_core dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .en       (en),
    .pwr_up_en(pwr_up_en),
    .tdo      (tdo)
  );

  localparam logic [127:0] K_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D_A = 128'hDEADBEEF_00112233_44556677_8899AABB;

  typedef struct {
    logic         do_rst;
    logic [3:0]   op;
    logic [127:0] payload;
    int           nbits;
    logic         pulse;
    int           exp_words;
    logic         w0_lit;
    logic [127:0] w0;
  } vec_t;

  vec_t         vecs [16];
  logic [127:0] exp_q [$];

  logic [127:0] key_m;
  logic         kv_m;
  int           wptr_m;
  logic [127:0] mem_m [4];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] op, input logic [127:0] pl,
                              input int nb, input logic pu, input int ew,
                              input logic wl, input logic [127:0] w0);
    vec_t v;
    v.do_rst = r; v.op = op; v.payload = pl; v.nbits = nb;
    v.pulse = pu; v.exp_words = ew; v.w0_lit = wl; v.w0 = w0;
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pwr_up_en = 1'b0; data_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    key_m = '0; kv_m = 1'b0; wptr_m = 0;
  endtask

  // Sends a frame (or nbits of one); tdo_seen reports any tdo activity meanwhile.
  task automatic send_frame(input logic [3:0] op, input logic [127:0] pl, input int nbits,
                            input logic pulse_at_start, output logic tdo_seen);
    logic [191:0] fr;
    logic [63:0]  r;
    r  = {$urandom(), $urandom()};
    fr = {pl, r[63:4], op};
    tdo_seen  = 1'b0;
    en        = 1'b1;
    pwr_up_en = pulse_at_start;
    data_i    = 1'($urandom());
    @(negedge clk);
    pwr_up_en = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      data_i = fr[i];
      tdo_seen |= tdo;
      @(negedge clk);
    end
    en = 1'b0; data_i = 1'b0;
    repeat (4) begin
      tdo_seen |= tdo;
      @(negedge clk);
    end
    if (nbits == 192) begin
      if (op == 4'h0) begin
        key_m = pl; kv_m = 1'b1;
      end else if (op == 4'h1 && kv_m && wptr_m < 4) begin
        mem_m[wptr_m] = pl ^ key_m;
        wptr_m++;
      end
    end
  endtask

  // Pulses pwr_up_en and compares the stream against the scoreboard queue.
  task automatic readout(input string tag);
    logic [127:0] got;
    logic [127:0] exp;
    logic         tail;
    int           n;
    pwr_up_en = 1'b1;
    @(negedge clk);
    pwr_up_en = 1'b0;
    n = exp_q.size();
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 128; b++) begin
        got[b] = tdo;
        @(negedge clk);
      end
      exp = exp_q.pop_front();
      chk($sformatf("%s word%0d", tag, w), got, exp);
    end
    tail = 1'b0;
    repeat (8) begin
      tail |= tdo;
      @(negedge clk);
    end
    chk($sformatf("%s tail", tag), 128'(tail), 128'(0));
  endtask

  initial begin
    logic [127:0] k2, t_pl;
    logic [127:0] got, exp_w;
    logic         seen;

    rst = 1'b1; en = 1'b0; pwr_up_en = 1'b0; data_i = 1'b0;
    k2   = rnd128();
    t_pl = rnd128();

    vecs[0]  = mk(1, 4'h0, K_A,        192, 1, 0, 0, '0);
    vecs[1]  = mk(0, 4'h1, K_A ^ D_A,  192, 1, 1, 1, D_A);
    vecs[2]  = mk(1, 4'h1, rnd128(),   192, 1, 0, 0, '0);
    vecs[3]  = mk(1, 4'h0, k2,         192, 0, 0, 0, '0);
    vecs[4]  = mk(0, 4'h1, rnd128(),   192, 0, 0, 0, '0);
    vecs[5]  = mk(0, 4'h1, rnd128(),   192, 0, 0, 0, '0);
    vecs[6]  = mk(0, 4'h1, rnd128(),   192, 0, 0, 0, '0);
    vecs[7]  = mk(0, 4'h1, rnd128(),   192, 0, 0, 0, '0);
    vecs[8]  = mk(0, 4'h1, rnd128(),   192, 1, 4, 0, '0);
    vecs[9]  = mk(1, 4'h0, '0,         192, 0, 0, 0, '0);
    vecs[10] = mk(0, 4'h0, rnd128(),   100, 0, 0, 0, '0);
    vecs[11] = mk(0, 4'h1, D_A,        192, 1, 1, 1, D_A);
    vecs[12] = mk(1, 4'h0, K_A,        192, 0, 0, 0, '0);
    vecs[13] = mk(0, 4'h7, rnd128(),   192, 0, 0, 0, '0);
    vecs[14] = mk(0, 4'h1, t_pl,       192, 1, 1, 1, t_pl ^ K_A);
    vecs[15] = mk(0, 4'h0, '0,         0,   1, 1, 1, t_pl ^ K_A);

    @(negedge clk);
    do_reset();
    chk("reset tdo", 128'(tdo), 128'(0));

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_rst) do_reset();
      if (vecs[i].nbits > 0) send_frame(vecs[i].op, vecs[i].payload, vecs[i].nbits, 1'b0, seen);
      if (vecs[i].pulse) begin
        for (int w = 0; w < vecs[i].exp_words; w++) begin
          exp_q.push_back((w == 0 && vecs[i].w0_lit) ? vecs[i].w0 : mem_m[w]);
        end
        readout($sformatf("vec%0d", i));
      end
    end

    // pwr_up_en on a start cycle: the frame wins, no stream appears.
    send_frame(4'h7, rnd128(), 192, 1'b1, seen);
    chk("pulse on start tdo quiet", 128'(seen), 128'(0));
    exp_q.push_back(t_pl ^ K_A);
    readout("after overlap");

    // en toggling during readout is ignored; reset mid-stream kills it.
    exp_w = t_pl ^ K_A;
    got   = '0;
    pwr_up_en = 1'b1;
    @(negedge clk);
    pwr_up_en = 1'b0;
    for (int b = 0; b < 20; b++) begin
      got[b] = tdo;
      en = (b >= 3 && b < 12);
      @(negedge clk);
    end
    en = 1'b0;
    chk("readout with en", 128'(got[19:0]), 128'(exp_w[19:0]));
    rst = 1'b1;
    @(negedge clk);
    chk("tdo after mid reset", 128'(tdo), 128'(0));
    rst = 1'b0;
    key_m = '0; kv_m = 1'b0; wptr_m = 0;
    readout("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
